spi_sequencer: RTL and testbench
================================

SPI_SEQUENCER -- requirements
Module: spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have parameter ADDR_W, default 10: buffer address width and byte-counter width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ctrl_reg  input  32  current control register value: [0] send, [1] all_ones, [2] all_zeros, [12:3] n_tx_end, [25:16] n_rx.
REQ-007 ctrl_wr  output  1  one-cycle write strobe to the control register.
REQ-008 ctrl_wdata  output  32  write-back value for the control register.
REQ-009 tx_addr  output  ADDR_W  transmit buffer read address.
REQ-010 tx_rdata  input  8  transmit buffer data, valid one cycle after tx_addr.
REQ-011 rx_we, rx_addr, rx_wdata  output  1/ADDR_W/8  receive buffer write port.
REQ-012 sclk, mosi, cs_n  output  1 each  SPI mode 0 master pins.
REQ-013 miso  input  1  SPI slave data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT, STORE, NEXT, DONE.
REQ-016 IDLE: cs_n=1, sclk=0; send=1 sampled -> count=0, tx_addr=0, go LOAD; send is sampled only in IDLE.
REQ-017 LOAD (1 cycle): byte = 8'hFF if all_ones, else 8'h00 if all_zeros, else tx_rdata; all_ones has priority; go SHIFT.
REQ-018 SHIFT: cs_n=0, 8 bits MSB first; mosi updates on SCLK falling edge (first bit at SHIFT entry); miso sampled on SCLK rising edge; one byte = 16*CLK_DIV cycles; sclk=0 on exit.
REQ-019 STORE (1 cycle): rx_we=1, rx_addr=count, rx_wdata=received byte.
REQ-020 NEXT (1 cycle): count==n_tx_end -> DONE; else count+1, tx_addr+1, LOAD; cs_n stays 0 between bytes.
REQ-021 n_tx_end=N SHALL transfer N+1 bytes (0 -> 1 byte, 1023 -> 1024 bytes); count never wraps.
REQ-022 DONE (1 cycle): cs_n=1, ctrl_wr=1, ctrl_wdata = ctrl_reg with [0]=0 and [25:16]=count+1 (truncated to 10 bits); go IDLE.
REQ-023 send deasserted or ctrl_reg changed mid-transfer SHALL NOT abort the transfer; n_tx_end and all_ones/all_zeros are re-read each LOAD/NEXT.
REQ-024 ctrl_wr SHALL be 0 in all states except DONE; rx_we 0 except STORE.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state IDLE, cs_n=1, sclk=0, mosi=0, ctrl_wr=0, ctrl_wdata=0, rx_we=0, rx_addr=0, rx_wdata=0, tx_addr=0, busy=0, count=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer without a ctrl_wr write-back.

Configuration
REQ-027 Macro SPI_SEQ_LOOPBACK_EN defined: the internal miso sample SHALL be mosi and the miso port SHALL be ignored; undefined: the miso port SHALL be sampled.

Structure
REQ-028 Package spi_pkg SHALL hold the state enum and the ctrl_reg bit-position/width constants (SEND_BIT, ALL_ONES_BIT, ALL_ZEROS_BIT, NTX_LSB/MSB, NRX_LSB/MSB).
REQ-029 Sub-module spi_shift_byte SHALL implement the SCLK divider and 8-bit shift (start, done, tx_byte, rx_byte); the FSM and counters stay in spi_sequencer.

Verification
REQ-030 Single byte: ctrl_reg=0x00000001, tx_rdata=0xA5, miso tied to mosi -> mosi shows 1010_0101, rx_wdata=0xA5 at rx_addr 0, ctrl_wr once with ctrl_wdata=0x00010000.
REQ-031 Four bytes: n_tx_end=3, buffer 0x11,0x22,0x33,0x44, slave returns 0xC3 -> rx addresses 0..3 all 0xC3, cs_n low continuously, ctrl_wdata[25:16]=4.
REQ-032 Fill patterns: all_ones=1 and all_zeros=1 -> mosi high for all 8 bits; all_zeros only -> mosi low.
REQ-033 Timing: CLK_DIV=2 -> SHIFT lasts 32 cycles, ctrl_wr exactly 1 cycle, busy falls the cycle after DONE.
REQ-034 Reset mid-byte: rst_n=0 after 3 bits of byte 1 -> cs_n=1 same cycle, no ctrl_wr; new send after reset restarts from tx_addr 0.
REQ-035 Loopback: compiled with SPI_SEQ_LOOPBACK_EN, miso held at 0, tx 0x5A -> rx_wdata=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sequencer: FSM states and the ctrl_reg field layout.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    STORE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int SEND_BIT      = 0;
  localparam int ALL_ONES_BIT  = 1;
  localparam int ALL_ZEROS_BIT = 2;
  localparam int NTX_LSB       = 3;
  localparam int NTX_MSB       = 12;
  localparam int NRX_LSB       = 16;
  localparam int NRX_MSB       = 25;
  localparam int NTX_W         = NTX_MSB - NTX_LSB + 1;
  localparam int NRX_W         = NRX_MSB - NRX_LSB + 1;

  // all_ones wins over all_zeros; otherwise the buffer byte goes out.
  function automatic logic [7:0] fill_byte(input logic all_ones, input logic all_zeros,
                                           input logic [7:0] data);
    if (all_ones)       return 8'hFF;
    else if (all_zeros) return 8'h00;
    else                return data;
  endfunction

endpackage

// File: rtl/spi_shift_byte.sv
// SCLK divider and 8-bit MSB-first mode-0 shifter; one byte takes 16*CLK_DIV cycles.
module spi_shift_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  logic       active;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic       half_tick;

  assign half_tick = active && (div_cnt == 8'(CLK_DIV - 1));
  // Final falling edge of bit 7: the caller leaves SHIFT on this cycle.
  assign done      = half_tick && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_byte <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= tx_byte[7];
      tx_sr   <= {tx_byte[6:0], 1'b0};
    end else if (active) begin
      if (half_tick) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (!sclk) begin
          rx_byte <= {rx_byte[6:0], miso};
        end else if (bit_cnt == 3'd7) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          mosi    <= tx_sr[7];
          tx_sr   <= {tx_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_sequencer.sv
// SPI mode-0 transfer sequencer driven by a control register and tx/rx buffers.
// Build option: SPI_SEQ_LOOPBACK_EN feeds mosi back as the miso sample.
module spi_sequencer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ctrl_reg,
  output logic              ctrl_wr,
  output logic [31:0]       ctrl_wdata,
  output logic [ADDR_W-1:0] tx_addr,
  input  logic [7:0]        tx_rdata,
  output logic              rx_we,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [7:0]        rx_wdata,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso,
  output logic              busy,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q;
  logic [NTX_W-1:0]  n_tx_end;
  logic              last_byte;
  logic              shift_done;
  logic              miso_s;
  logic [7:0]        load_byte;
  logic [7:0]        rx_byte;
  logic [NRX_W-1:0]  n_rx;

  assign n_tx_end  = ctrl_reg[NTX_MSB:NTX_LSB];
  // >= and the all-ones test keep count from wrapping if n_tx_end shrinks mid-transfer.
  assign last_byte = (32'(count_q) >= 32'(n_tx_end)) || (count_q == '1);
  assign load_byte = fill_byte(ctrl_reg[ALL_ONES_BIT], ctrl_reg[ALL_ZEROS_BIT], tx_rdata);
  assign n_rx      = NRX_W'(count_q) + NRX_W'(1);

`ifdef SPI_SEQ_LOOPBACK_EN
  assign miso_s = mosi;
  logic unused_miso;
  assign unused_miso = miso;
`else
  assign miso_s = miso;
`endif

  // Shifter handshake: start is a one-cycle pulse (LOAD) accepted only while the
  // shifter is idle; done pulses in the last SHIFT cycle and rx_byte holds from then on.
  spi_shift_byte #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (state_q == LOAD),
    .tx_byte (load_byte),
    .miso    (miso_s),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (shift_done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ctrl_reg[SEND_BIT]) count_q <= '0;
      else if (state_q == NEXT && !last_byte)    count_q <= count_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_reg[SEND_BIT]) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = STORE;
      STORE:   state_d = NEXT;
      NEXT:    state_d = last_byte ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_addr leads LOAD by one cycle so the buffer's registered read lands in LOAD.
  always_comb begin
    tx_addr = count_q;
    if (state_q == IDLE)      tx_addr = '0;
    else if (state_q == NEXT) tx_addr = count_q + ADDR_W'(1);
  end

  always_comb begin
    ctrl_wdata = '0;
    if (state_q == DONE) begin
      ctrl_wdata                  = ctrl_reg;
      ctrl_wdata[NRX_MSB:NRX_LSB] = n_rx;
      ctrl_wdata[SEND_BIT]        = 1'b0;
    end
  end

  assign ctrl_wr   = (state_q == DONE);
  assign rx_we     = (state_q == STORE);
  assign rx_addr   = count_q;
  assign rx_wdata  = rx_byte;
  assign cs_n      = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_sequencer.sv
// Self-checking bench for spi_sequencer: buffer and SPI slave models, randomized transfers.
module tb_spi_sequencer;

  localparam int CLK_DIV = 2;
  localparam int ADDR_W  = 10;
  localparam int BYTE_CYC = 16 * CLK_DIV + 3;

  logic              clk;
  logic              rst_n;
  logic [31:0]       ctrl_reg;
  logic              ctrl_wr;
  logic [31:0]       ctrl_wdata;
  logic [ADDR_W-1:0] tx_addr;
  logic [7:0]        tx_rdata;
  logic              rx_we;
  logic [ADDR_W-1:0] rx_addr;
  logic [7:0]        rx_wdata;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              miso;
  logic              busy;
  spi_pkg::state_t   dbg_state;

  int total = 0;
  int bad   = 0;

  spi_sequencer #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_reg   (ctrl_reg),
    .ctrl_wr    (ctrl_wr),
    .ctrl_wdata (ctrl_wdata),
    .tx_addr    (tx_addr),
    .tx_rdata   (tx_rdata),
    .rx_we      (rx_we),
    .rx_addr    (rx_addr),
    .rx_wdata   (rx_wdata),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- buffer and slave models ----------------
  logic [7:0] tx_mem  [1024];
  logic [7:0] slv_mem [1024];
  logic       loop_mode;
  int         slv_bits;
  logic       slave_bit;

  always @(posedge clk) tx_rdata <= tx_mem[tx_addr];

  always_comb slave_bit = slv_mem[(slv_bits / 8) % 1024][7 - (slv_bits % 8)];

`ifdef SPI_SEQ_LOOPBACK_EN
  assign miso = 1'b0;
`else
  assign miso = loop_mode ? mosi : slave_bit;
`endif

  // ---------------- monitors ----------------
  logic [7:0]        obs_tx_q[$];
  logic [ADDR_W-1:0] rx_addr_q[$];
  logic [7:0]        rx_data_q[$];
  logic [7:0]        mosi_sr;
  int                mosi_n;
  int                wr_cnt = 0;
  int                busy_cyc = 0;
  int                cs_rise = 0;

  always @(posedge sclk) begin
    logic [7:0] b;
    b       = {mosi_sr[6:0], mosi};
    mosi_sr = b;
    mosi_n  = mosi_n + 1;
    if (mosi_n % 8 == 0) obs_tx_q.push_back(b);
    slv_bits = slv_bits + 1;
  end

  always @(negedge clk) begin
    if (rx_we) begin
      rx_addr_q.push_back(rx_addr);
      rx_data_q.push_back(rx_wdata);
    end
    if (ctrl_wr) wr_cnt = wr_cnt + 1;
    if (busy)    busy_cyc = busy_cyc + 1;
  end

  always @(posedge cs_n) cs_rise = cs_rise + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_tx(input logic [31:0] ctrl, input int i);
    if (ctrl[1])      return 8'hFF;
    else if (ctrl[2]) return 8'h00;
    else              return tx_mem[i];
  endfunction

  function automatic logic [7:0] exp_rx(input logic [31:0] ctrl, input int i);
`ifdef SPI_SEQ_LOOPBACK_EN
    return exp_tx(ctrl, i);
`else
    return loop_mode ? exp_tx(ctrl, i) : slv_mem[i];
`endif
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] ctrl, input int nbytes);
    logic [31:0] w;
    logic [9:0]  n10;
    n10     = 10'(nbytes);
    w       = ctrl;
    w[0]    = 1'b0;
    w[25:16] = n10;
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_xfer(input string name, input logic [31:0] ctrl, input bit drop_send);
    int          n;
    int          wr0;
    int          busy0;
    int          cs0;
    int          limit;
    bit          seen;
    logic [31:0] got_wdata;
    n     = int'(ctrl[12:3]) + 1;
    limit = n * BYTE_CYC + 50;
    obs_tx_q.delete();
    rx_addr_q.delete();
    rx_data_q.delete();
    mosi_n   = 0;
    slv_bits = 0;
    wr0      = wr_cnt;
    busy0    = busy_cyc;
    cs0      = cs_rise;
    seen     = 1'b0;
    got_wdata = '0;
    @(negedge clk);
    ctrl_reg = ctrl;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (drop_send && cyc == 5) ctrl_reg[0] = 1'b0;
      if (ctrl_wr) begin
        seen      = 1'b1;
        got_wdata = ctrl_wdata;
        check({name, "_done_cs_n"}, 32'(cs_n), 32'd1);
        check({name, "_done_busy"}, 32'(busy), 32'd1);
        ctrl_reg = '0;
        break;
      end
    end
    check({name, "_completed"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
    check({name, "_ctrl_wdata"}, got_wdata, exp_wdata(ctrl, n));
    check({name, "_wr_count"}, 32'(wr_cnt - wr0), 32'd1);
    check({name, "_cs_rises"}, 32'(cs_rise - cs0), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy_cyc - busy0), 32'(n * BYTE_CYC + 1));
    check({name, "_tx_bytes"}, 32'(obs_tx_q.size()), 32'(n));
    check({name, "_rx_writes"}, 32'(rx_data_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < obs_tx_q.size()) check({name, "_mosi_byte"}, 32'(obs_tx_q[i]), 32'(exp_tx(ctrl, i)));
      if (i < rx_data_q.size()) begin
        check({name, "_rx_addr"}, 32'(rx_addr_q[i]), 32'(i));
        check({name, "_rx_data"}, 32'(rx_data_q[i]), 32'(exp_rx(ctrl, i)));
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      tx_mem[i]  = 8'($urandom_range(0, 255));
      slv_mem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  function automatic logic [31:0] make_ctrl(input int n, input bit ones, input bit zeros);
    logic [31:0] c;
    logic [9:0]  ntx;
    c       = $urandom;
    ntx     = 10'(n - 1);
    c[12:3] = ntx;
    c[0]    = 1'b1;
    c[1]    = ones;
    c[2]    = zeros;
    return c;
  endfunction

  task automatic reset_mid_byte();
    int wr0;
    bit hit;
    fill_random(3);
    mosi_n   = 0;
    slv_bits = 0;
    hit      = 1'b0;
    @(negedge clk);
    ctrl_reg = make_ctrl(3, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (mosi_n == 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reached_bit3", 32'(hit), 32'd1);
    wr0   = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_addr", 32'(tx_addr), 32'd0);
    check("rst_rx_addr", 32'(rx_addr), 32'd0);
    check("rst_rx_wdata", 32'(rx_wdata), 32'd0);
    ctrl_reg = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_writeback", 32'(wr_cnt - wr0), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n     = 1'b0;
    ctrl_reg  = '0;
    loop_mode = 1'b0;
    mosi_n    = 0;
    mosi_sr   = '0;
    slv_bits  = 0;
    for (int i = 0; i < 1024; i++) begin
      tx_mem[i]  = '0;
      slv_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ctrl_wr", 32'(ctrl_wr), 32'd0);
    check("reset_ctrl_wdata", ctrl_wdata, 32'd0);
    check("reset_rx_we", 32'(rx_we), 32'd0);
    check("reset_tx_addr", 32'(tx_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    loop_mode = 1'b1;
    tx_mem[0] = 8'hA5;
    run_xfer("single", 32'h0000_0001, 1'b0);

    loop_mode = 1'b0;
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;
    for (int i = 0; i < 4; i++) slv_mem[i] = 8'hC3;
    run_xfer("four", 32'h0000_0019, 1'b0);

    fill_random(3);
    run_xfer("fill_both", make_ctrl(3, 1'b1, 1'b1), 1'b0);
    fill_random(2);
    run_xfer("fill_zeros", make_ctrl(2, 1'b0, 1'b1), 1'b0);

    tx_mem[0] = 8'h5A;
    slv_mem[0] = 8'($urandom_range(0, 255));
    run_xfer("tx_5a", 32'h0000_0001, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 5);
      fill_random(n);
      loop_mode = ($urandom_range(0, 3) == 0);
      run_xfer("random", make_ctrl(n, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)),
               bit'($urandom_range(0, 1)));
    end

    loop_mode = 1'b0;
    reset_mid_byte();
    fill_random(2);
    run_xfer("after_reset", make_ctrl(2, 1'b0, 1'b0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
